// File: rtl/mem_arbiter.sv
// Two-port (fetch/data) arbiter in front of a single-ported byte memory.
// IDLE -> ACC -> RESP per transaction, data-first with fetch anti-starvation.
module mem_arbiter #(
  parameter int STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_req,
  input  logic [8:0]  if_addr,
  output logic        if_gnt,
  output logic        if_valid,
  output logic [31:0] if_rdata,
  output logic        if_err,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [8:0]  d_addr,
  input  logic [31:0] d_wdata,
  input  logic [2:0]  d_funct3,
  output logic        d_gnt,
  output logic        d_valid,
  output logic [31:0] d_rdata,
  output logic        d_err,
  output logic [8:0]  mem_addr,
  output logic        mem_read,
  output logic        mem_write,
  output logic [2:0]  mem_funct3,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic [31:0] mem_inst
);

  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] SMAX = SW'(STARVE_MAX);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e         state_q, state_d;
  logic [SW-1:0]  starve_q, starve_d;
  logic           fetch_q, fetch_d;
  logic           we_q, we_d;
  logic           err_q, err_d;
  logic [8:0]     addr_q, addr_d;
  logic [31:0]    wdata_q, wdata_d;
  logic [2:0]     f3_q, f3_d;
  logic [31:0]    rdata_q, rdata_d;

  logic idle, acc, resp;
  logic fetch_wins;
  logic d_bad_align, d_bad_code, d_bad;
  logic if_bad;

  assign idle = (state_q == IDLE);
  assign acc  = (state_q == ACC);
  assign resp = (state_q == RESP);

  // Data normally wins; fetch wins alone or once it has starved long enough.
  assign fetch_wins = if_req & (~d_req | (starve_q == SMAX));
  assign if_gnt = rst_n & idle & fetch_wins;
  assign d_gnt  = rst_n & idle & d_req & ~fetch_wins;

  // Access legality, evaluated on the requester's live inputs at grant.
  always_comb begin
    d_bad_align = 1'b0;
    if (d_funct3[1:0] == 2'b10 && d_addr[1:0] != 2'b00) d_bad_align = 1'b1;
    if (d_funct3[1:0] == 2'b01 && d_addr[0]) d_bad_align = 1'b1;
    if (d_we)
      d_bad_code = ~(d_funct3 == 3'b000 || d_funct3 == 3'b001 ||
                     d_funct3 == 3'b010);
    else
      d_bad_code = ~(d_funct3 == 3'b000 || d_funct3 == 3'b001 ||
                     d_funct3 == 3'b010 || d_funct3 == 3'b100 ||
                     d_funct3 == 3'b101);
    d_bad  = d_bad_align | d_bad_code;
    if_bad = (if_addr[1:0] != 2'b00);
  end

  // Next-state: transaction sequencing, request latching, starvation count.
  always_comb begin
    state_d  = state_q;
    starve_d = starve_q;
    fetch_d  = fetch_q;
    we_d     = we_q;
    err_d    = err_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    f3_d     = f3_q;
    rdata_d  = rdata_q;
    unique case (state_q)
      IDLE: begin
        if (if_gnt) begin
          state_d  = ACC;
          starve_d = '0;
          fetch_d  = 1'b1;
          we_d     = 1'b0;
          err_d    = if_bad;
          addr_d   = if_addr;
          wdata_d  = '0;
          f3_d     = 3'b010;
        end else if (d_gnt) begin
          state_d  = ACC;
          if (if_req && starve_q != SMAX) starve_d = starve_q + 1'b1;
          fetch_d  = 1'b0;
          we_d     = d_we;
          err_d    = d_bad;
          addr_d   = d_addr;
          wdata_d  = d_wdata;
          f3_d     = d_funct3;
        end
      end
      ACC: begin
        state_d = RESP;
        if (err_q || we_q) rdata_d = '0;
        else if (fetch_q)  rdata_d = mem_inst;
        else               rdata_d = mem_rdata;
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State registers with synchronous active-low clear.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      starve_q <= '0;
      fetch_q  <= 1'b0;
      we_q     <= 1'b0;
      err_q    <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      f3_q     <= '0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
      fetch_q  <= fetch_d;
      we_q     <= we_d;
      err_q    <= err_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      f3_q     <= f3_d;
      rdata_q  <= rdata_d;
    end
  end

  // Memory strobes are cut by rst_n so a reset in ACC never writes.
  assign mem_read   = rst_n & acc & ~err_q & ~we_q;
  assign mem_write  = rst_n & acc & ~err_q & we_q;
  assign mem_addr   = acc ? addr_q  : '0;
  assign mem_funct3 = acc ? f3_q    : '0;
  assign mem_wdata  = acc ? wdata_q : '0;

  assign if_valid = resp & fetch_q;
  assign d_valid  = resp & ~fetch_q;
  assign if_rdata = (resp & fetch_q)  ? rdata_q : '0;
  assign d_rdata  = (resp & ~fetch_q) ? rdata_q : '0;
  assign if_err   = resp & fetch_q & err_q;
  assign d_err    = resp & ~fetch_q & err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a byte-array memory model.
// Inputs driven and outputs sampled 1ns after each rising edge.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_req;
  logic [8:0]  if_addr;
  logic        if_gnt, if_valid, if_err;
  logic [31:0] if_rdata;
  logic        d_req, d_we;
  logic [8:0]  d_addr;
  logic [31:0] d_wdata;
  logic [2:0]  d_funct3;
  logic        d_gnt, d_valid, d_err;
  logic [31:0] d_rdata;
  logic [8:0]  mem_addr;
  logic        mem_read, mem_write;
  logic [2:0]  mem_funct3;
  logic [31:0] mem_wdata, mem_rdata, mem_inst;

  int n_chk = 0;
  int n_fail = 0;

  logic [7:0] m [0:511];

  mem_arbiter #(.STARVE_MAX(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_valid(if_valid), .if_rdata(if_rdata), .if_err(if_err),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_funct3(d_funct3), .d_gnt(d_gnt), .d_valid(d_valid),
    .d_rdata(d_rdata), .d_err(d_err),
    .mem_addr(mem_addr), .mem_read(mem_read), .mem_write(mem_write),
    .mem_funct3(mem_funct3), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_inst(mem_inst)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] word_at(input logic [8:0] a);
    logic [8:0] a1, a2, a3;
    a1 = a + 9'd1;
    a2 = a + 9'd2;
    a3 = a + 9'd3;
    return {m[a3], m[a2], m[a1], m[a]};
  endfunction

  // Combinational memory read ports.
  always_comb begin
    mem_inst = word_at(mem_addr);
    case (mem_funct3)
      3'b000: mem_rdata = {{24{m[mem_addr][7]}}, m[mem_addr]};
      3'b001: mem_rdata = {{16{word_at(mem_addr)[15]}},
                           word_at(mem_addr)[15:0]};
      3'b100: mem_rdata = {24'd0, m[mem_addr]};
      3'b101: mem_rdata = {16'd0, word_at(mem_addr)[15:0]};
      default: mem_rdata = word_at(mem_addr);
    endcase
  end

  // Memory write port.
  always @(posedge clk) begin
    if (mem_write) begin
      m[mem_addr] <= mem_wdata[7:0];
      if (mem_funct3 != 3'b000) m[mem_addr + 9'd1] <= mem_wdata[15:8];
      if (mem_funct3 == 3'b010) begin
        m[mem_addr + 9'd2] <= mem_wdata[23:16];
        m[mem_addr + 9'd3] <= mem_wdata[31:24];
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, " gnt"}, {30'd0, if_gnt, d_gnt}, 32'd0);
    chk({tag, " valid"}, {28'd0, if_valid, d_valid, if_err, d_err}, 32'd0);
    chk({tag, " rd"}, if_rdata | d_rdata, 32'd0);
    chk({tag, " strobes"}, {30'd0, mem_read, mem_write}, 32'd0);
    chk({tag, " addr"}, {20'd0, mem_funct3, mem_addr}, 32'd0);
    chk({tag, " wdata"}, mem_wdata, 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 512; i++) m[i] = 8'h00;
    m[100] = 8'h98; m[101] = 8'hEF; m[102] = 8'hCD; m[103] = 8'hAB;
    m[8] = 8'h13;
    m[20] = 8'h5A;

    rst_n = 1'b0;
    if_req = 1'b0; if_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0;
    d_wdata = '0; d_funct3 = '0;
    step(); step();
    rst_n = 1'b1;
    #1;
    chk_quiet("reset");

    // Load word from 100.
    d_req = 1'b1; d_we = 1'b0; d_addr = 9'd100; d_funct3 = 3'b010;
    #1;
    chk("lw gnt", {31'd0, d_gnt}, 32'd1);
    chk("lw if_gnt", {31'd0, if_gnt}, 32'd0);
    step();
    d_req = 1'b0;
    chk("lw read", {31'd0, mem_read}, 32'd1);
    chk("lw write", {31'd0, mem_write}, 32'd0);
    chk("lw addr", {23'd0, mem_addr}, 32'd100);
    step();
    chk("lw valid", {31'd0, d_valid}, 32'd1);
    chk("lw rdata", d_rdata, 32'hABCDEF98);
    chk("lw err", {31'd0, d_err}, 32'd0);
    step();
    chk_quiet("lw after");

    // Store word to 16, then load it back.
    d_req = 1'b1; d_we = 1'b1; d_addr = 9'd16;
    d_wdata = 32'h12345678; d_funct3 = 3'b010;
    #1;
    chk("sw gnt", {31'd0, d_gnt}, 32'd1);
    step();
    d_req = 1'b0;
    chk("sw write", {31'd0, mem_write}, 32'd1);
    chk("sw read", {31'd0, mem_read}, 32'd0);
    chk("sw wdata", mem_wdata, 32'h12345678);
    step();
    chk("sw write off", {31'd0, mem_write}, 32'd0);
    chk("sw valid", {31'd0, d_valid}, 32'd1);
    chk("sw rdata", d_rdata, 32'd0);
    step();
    d_req = 1'b1; d_we = 1'b0; d_addr = 9'd16; d_funct3 = 3'b010;
    #1;
    chk("lw16 gnt", {31'd0, d_gnt}, 32'd1);
    step();
    d_req = 1'b0;
    step();
    chk("lw16 rdata", d_rdata, 32'h12345678);
    step();

    // Misaligned load word at 102.
    d_req = 1'b1; d_we = 1'b0; d_addr = 9'd102; d_funct3 = 3'b010;
    #1;
    chk("mis gnt", {31'd0, d_gnt}, 32'd1);
    step();
    d_req = 1'b0;
    chk("mis read", {31'd0, mem_read}, 32'd0);
    step();
    chk("mis valid", {31'd0, d_valid}, 32'd1);
    chk("mis err", {31'd0, d_err}, 32'd1);
    chk("mis rdata", d_rdata, 32'd0);
    step();
    chk("mis err off", {31'd0, d_err}, 32'd0);

    // Store with illegal width code 100.
    d_req = 1'b1; d_we = 1'b1; d_addr = 9'd40; d_funct3 = 3'b100;
    d_wdata = 32'hFFFFFFFF;
    #1;
    step();
    d_req = 1'b0;
    chk("sbad write", {31'd0, mem_write}, 32'd0);
    step();
    chk("sbad err", {31'd0, d_err}, 32'd1);
    step();

    // Misaligned fetch at 6.
    if_req = 1'b1; if_addr = 9'd6;
    #1;
    chk("fmis gnt", {31'd0, if_gnt}, 32'd1);
    step();
    if_req = 1'b0;
    chk("fmis read", {31'd0, mem_read}, 32'd0);
    step();
    chk("fmis valid", {31'd0, if_valid}, 32'd1);
    chk("fmis err", {31'd0, if_err}, 32'd1);
    chk("fmis dvalid", {31'd0, d_valid}, 32'd0);
    step();

    // Contention: data wins four times, fetch wins the fifth.
    if_req = 1'b1; if_addr = 9'd8;
    d_req = 1'b1; d_we = 1'b0; d_addr = 9'd100; d_funct3 = 3'b010;
    #1;
    for (int k = 0; k < 4; k++) begin
      chk("arb d", {30'd0, if_gnt, d_gnt}, 32'd1);
      step();
      chk("arb acc nognt", {30'd0, if_gnt, d_gnt}, 32'd0);
      step();
      chk("arb d rdata", d_rdata, 32'hABCDEF98);
      step();
    end
    chk("arb f", {30'd0, if_gnt, d_gnt}, 32'd2);
    step();
    chk("arb f read", {31'd0, mem_read}, 32'd1);
    chk("arb f addr", {23'd0, mem_addr}, 32'd8);
    chk("arb f f3", {29'd0, mem_funct3}, 32'd2);
    step();
    chk("arb f valid", {30'd0, if_valid, d_valid}, 32'd2);
    chk("arb f inst", if_rdata, 32'h00000013);
    chk("arb f err", {31'd0, if_err}, 32'd0);
    step();
    chk("arb after", {30'd0, if_gnt, d_gnt}, 32'd1);
    if_req = 1'b0; d_req = 1'b0;
    step(); step(); step();

    // Reset asserted during the ACC cycle of a byte store to 20.
    d_req = 1'b1; d_we = 1'b1; d_addr = 9'd20;
    d_wdata = 32'h000000C3; d_funct3 = 3'b000;
    #1;
    chk("rst gnt", {31'd0, d_gnt}, 32'd1);
    step();
    d_req = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("rst write", {31'd0, mem_write}, 32'd0);
    step();
    chk("rst valid", {31'd0, d_valid}, 32'd0);
    rst_n = 1'b1;
    #1;
    chk_quiet("rst after");
    step();
    chk("rst valid2", {31'd0, d_valid}, 32'd0);
    chk("rst byte20", {24'd0, m[20]}, 32'h5A);

    // Idle for ten cycles.
    for (int k = 0; k < 10; k++) begin
      step();
      chk_quiet("idle");
    end
    chk("idle starve", 32'(dut.starve_q), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
